// File: rtl/sc_pointscheduler_pkg.sv
// Shared definitions for the point scheduler: FSM encodings and sizing helpers.
package sc_pointscheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } sched_state_e;

  // Width of a requester index / round-robin pointer for n requesters.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Saturation value of a w-bit pending counter.
  function automatic int unsigned pend_sat(input int unsigned w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/sc_rr_arbiter.sv
// Combinational round-robin pick among NREQ nonzero flags.
// Search starts at ptr+1 and wraps modulo NREQ.
// Ports:
//   nonzero      in  NREQ   requester has work
//   ptr          in  PTR_W  last winner
//   win_onehot_c out NREQ   one-hot winner (0 if none)
//   win_idx_c    out PTR_W  winner index
//   win_valid_c  out 1      some requester selected
import sc_pointscheduler_pkg::*;

module sc_rr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [NREQ-1:0]  nonzero,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  win_onehot_c,
  output logic [PTR_W-1:0] win_idx_c,
  output logic             win_valid_c
);

  logic [PTR_W-1:0] idx;

  // First nonzero flag after the pointer wins.
  always_comb begin
    win_onehot_c = '0;
    win_idx_c    = '0;
    win_valid_c  = 1'b0;
    idx          = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = PTR_W'((32'(ptr) + k) % NREQ);
      if (!win_valid_c && nonzero[idx]) begin
        win_valid_c       = 1'b1;
        win_idx_c         = idx;
        win_onehot_c[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sc_pointscheduler.sv
// Round-robin scheduler that queues one-cycle point events per requester and
// feeds the shared point counter one active-low upcount pulse per point,
// with a one-cycle gap between pulses.
// Optional feature macro: SC_POINTSCHEDULER_LIMIT_EN (adds count/done ports and
// stops issuing once the counter reaches POINT_LIMIT).
// Ports:
//   SC_POINTSCHEDULER_CLOCK_50        in   clock, rising edge
//   SC_POINTSCHEDULER_RESET_InLow     in   async active-low reset
//   SC_POINTSCHEDULER_req_InBUS       in   per-requester point pulse
//   SC_POINTSCHEDULER_enable_InHigh   in   issuing allowed
//   SC_POINTSCHEDULER_upcount_OutLow  out  low one cycle per point
//   SC_POINTSCHEDULER_grant_OutBUS    out  one-hot owner of current pulse
//   SC_POINTSCHEDULER_busy_OutHigh    out  work outstanding
//   SC_POINTSCHEDULER_overflow_OutBUS out  sticky per-requester drop flag
//   SC_POINTSCHEDULER_count_InBUS     in   counter value (limit build only)
//   SC_POINTSCHEDULER_done_OutHigh    out  limit reached (limit build only)
import sc_pointscheduler_pkg::*;

module sc_pointscheduler #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned PEND_W      = 3,
  parameter int unsigned DATAWIDTH   = 8,
  parameter int unsigned POINT_LIMIT = 10
) (
  input  logic            SC_POINTSCHEDULER_CLOCK_50,
  input  logic            SC_POINTSCHEDULER_RESET_InLow,
  input  logic [NREQ-1:0] SC_POINTSCHEDULER_req_InBUS,
  input  logic            SC_POINTSCHEDULER_enable_InHigh,
  output logic            SC_POINTSCHEDULER_upcount_OutLow,
  output logic [NREQ-1:0] SC_POINTSCHEDULER_grant_OutBUS,
  output logic            SC_POINTSCHEDULER_busy_OutHigh,
  output logic [NREQ-1:0] SC_POINTSCHEDULER_overflow_OutBUS
`ifdef SC_POINTSCHEDULER_LIMIT_EN
  ,
  input  logic [DATAWIDTH-1:0] SC_POINTSCHEDULER_count_InBUS,
  output logic                 SC_POINTSCHEDULER_done_OutHigh
`endif
);

  localparam int unsigned PTR_W = ptr_width(NREQ);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(pend_sat(PEND_W));

  // Reject unsupported configurations at elaboration.
  if (NREQ < 2 || NREQ > 8 || POINT_LIMIT >= (1 << DATAWIDTH)) begin : g_bad_cfg
    $error("sc_pointscheduler: unsupported parameter set");
  end

  sched_state_e      state_q, state_d;
  logic [PEND_W-1:0] pend_q [NREQ];
  logic [PEND_W-1:0] pend_d [NREQ];
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  win_idx_q, win_idx_d;
  logic [NREQ-1:0]   grant_d, overflow_d, granted_c, nonzero_c;
  logic              upcount_d, busy_d, limit_hit_c, can_issue_c;
  logic [NREQ-1:0]   arb_onehot_c;
  logic [PTR_W-1:0]  arb_idx_c;
  logic              arb_valid_c;

  // Limit gating: only present in the limit build.
`ifdef SC_POINTSCHEDULER_LIMIT_EN
  assign limit_hit_c = (SC_POINTSCHEDULER_count_InBUS >= DATAWIDTH'(POINT_LIMIT));

  always_ff @(posedge SC_POINTSCHEDULER_CLOCK_50 or negedge SC_POINTSCHEDULER_RESET_InLow) begin
    if (!SC_POINTSCHEDULER_RESET_InLow) SC_POINTSCHEDULER_done_OutHigh <= 1'b0;
    else                                SC_POINTSCHEDULER_done_OutHigh <= limit_hit_c;
  end
`else
  assign limit_hit_c = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < NREQ; i++) nonzero_c[i] = (pend_q[i] != '0);
  end

  sc_rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_arb (
    .nonzero      (nonzero_c),
    .ptr          (ptr_q),
    .win_onehot_c (arb_onehot_c),
    .win_idx_c    (arb_idx_c),
    .win_valid_c  (arb_valid_c)
  );

  assign can_issue_c = SC_POINTSCHEDULER_enable_InHigh && arb_valid_c && !limit_hit_c;
  // The grant register holds the winner for the whole ISSUE cycle.
  assign granted_c = (state_q == ST_ISSUE) ? SC_POINTSCHEDULER_grant_OutBUS : '0;

  // Next-state, pending counters and registered-output values.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_idx_d  = win_idx_q;
    grant_d    = '0;
    upcount_d  = 1'b1;
    overflow_d = SC_POINTSCHEDULER_overflow_OutBUS;
    pend_d     = pend_q;
    busy_d     = 1'b0;

    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (can_issue_c) begin
          state_d   = ST_ISSUE;
          win_idx_d = arb_idx_c;
          grant_d   = arb_onehot_c;
          upcount_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_GAP;
        ptr_d   = win_idx_q;
      end
      default: state_d = ST_IDLE;
    endcase

    // Request and grant in the same cycle cancel out.
    for (int i = 0; i < NREQ; i++) begin
      case ({SC_POINTSCHEDULER_req_InBUS[i], granted_c[i]})
        2'b10: begin
          if (pend_q[i] == PEND_MAX) overflow_d[i] = 1'b1;
          else                       pend_d[i] = pend_q[i] + PEND_W'(1);
        end
        2'b01:   pend_d[i] = pend_q[i] - PEND_W'(1);
        default: pend_d[i] = pend_q[i];
      endcase
    end

    busy_d = (state_d != ST_IDLE);
    for (int i = 0; i < NREQ; i++) busy_d = busy_d | (pend_d[i] != '0);
  end

  always_ff @(posedge SC_POINTSCHEDULER_CLOCK_50 or negedge SC_POINTSCHEDULER_RESET_InLow) begin
    if (!SC_POINTSCHEDULER_RESET_InLow) begin
      state_q                           <= ST_IDLE;
      ptr_q                             <= PTR_W'(NREQ - 1);
      win_idx_q                         <= '0;
      SC_POINTSCHEDULER_upcount_OutLow  <= 1'b1;
      SC_POINTSCHEDULER_grant_OutBUS    <= '0;
      SC_POINTSCHEDULER_busy_OutHigh    <= 1'b0;
      SC_POINTSCHEDULER_overflow_OutBUS <= '0;
      for (int i = 0; i < NREQ; i++) pend_q[i] <= '0;
    end else begin
      state_q                           <= state_d;
      ptr_q                             <= ptr_d;
      win_idx_q                         <= win_idx_d;
      SC_POINTSCHEDULER_upcount_OutLow  <= upcount_d;
      SC_POINTSCHEDULER_grant_OutBUS    <= grant_d;
      SC_POINTSCHEDULER_busy_OutHigh    <= busy_d;
      SC_POINTSCHEDULER_overflow_OutBUS <= overflow_d;
      for (int i = 0; i < NREQ; i++) pend_q[i] <= pend_d[i];
    end
  end

endmodule
